// File: rtl/audio_serializer_pkg.sv
// Shared definitions for the audio serializer: serializer states, default widths
// and a small counter-width helper.
package audio_serializer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int DEFAULT_DATA_WIDTH = 16;
  localparam int DEFAULT_FIFO_DEPTH = 4;
  localparam int DEFAULT_CLK_DIV    = 4;

  // Width for a counter spanning 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/audio_serializer_if.sv
// Sample input, flag control and codec-style serial link of the audio serializer.
interface audio_serializer_if
  import audio_serializer_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);

  logic [DATA_WIDTH-1:0] sample_in;
  logic                  sample_valid;
  logic                  clear_flags;
  logic                  fifo_full;
  logic                  bclk;
  logic                  lrclk;
  logic                  sdata;
  logic                  overflow;
  logic                  underrun;

  modport master (
    output sample_in, sample_valid, clear_flags,
    input  fifo_full, bclk, lrclk, sdata, overflow, underrun
  );

  modport slave (
    input  sample_in, sample_valid, clear_flags,
    output fifo_full, bclk, lrclk, sdata, overflow, underrun
  );

endinterface

// File: rtl/audio_serializer_sample_fifo.sv
// Circular sample buffer with registered count; a push while full is accepted
// only when a pop happens on the same edge.
module sample_fifo
  import audio_serializer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && (!full || do_pop);
  assign full    = (count == CW'(DEPTH));
  assign dout    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/audio_serializer.sv
// Buffers filtered mono samples and sends each one MSB-first in both slots of a
// left-justified frame, with sticky overflow/underrun flags.
module audio_serializer
  import audio_serializer_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
  parameter int CLK_DIV    = DEFAULT_CLK_DIV
) (
  input logic               clock,
  input logic               reset,
  audio_serializer_if.slave bus
);

  localparam int CW    = $clog2(FIFO_DEPTH) + 1;
  localparam int DIV_W = cnt_width(CLK_DIV);
  localparam int BIT_W = $clog2(2 * DATA_WIDTH);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * DATA_WIDTH - 1);
  localparam logic [BIT_W-1:0] BIT_HALF = BIT_W'(DATA_WIDTH);

  state_t                state, state_n;
  logic [DATA_WIDTH-1:0] hold, hold_n;
  logic [DATA_WIDTH-1:0] shift, shift_n;
  logic [DIV_W-1:0]      div_cnt, div_n;
  logic [BIT_W-1:0]      bit_cnt, bit_n, bit_inc;
  logic                  bclk_r, bclk_n;
  logic                  lrclk_r, lrclk_n;
  logic                  sdata_r, sdata_n;
  logic                  overflow_r, overflow_n, overflow_set;
  logic                  underrun_r, underrun_n, underrun_set;
  logic                  pop;
  logic [DATA_WIDTH-1:0] fifo_dout;
  logic [CW-1:0]         fifo_count;
  logic                  fifo_full_int;

  sample_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (bus.sample_valid),
    .pop   (pop),
    .din   (bus.sample_in),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full_int)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      hold       <= '0;
      shift      <= '0;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      bclk_r     <= 1'b0;
      lrclk_r    <= 1'b0;
      sdata_r    <= 1'b0;
      overflow_r <= 1'b0;
      underrun_r <= 1'b0;
    end else begin
      state      <= state_n;
      hold       <= hold_n;
      shift      <= shift_n;
      div_cnt    <= div_n;
      bit_cnt    <= bit_n;
      bclk_r     <= bclk_n;
      lrclk_r    <= lrclk_n;
      sdata_r    <= sdata_n;
      overflow_r <= overflow_n;
      underrun_r <= underrun_n;
    end
  end

  // Serial data and lrclk only move on falling bclk, so they are stable whenever
  // the codec samples on rising bclk.
  always_comb begin
    state_n      = state;
    hold_n       = hold;
    shift_n      = shift;
    div_n        = div_cnt;
    bit_n        = bit_cnt;
    bclk_n       = bclk_r;
    lrclk_n      = lrclk_r;
    sdata_n      = sdata_r;
    pop          = 1'b0;
    underrun_set = 1'b0;
    bit_inc      = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + BIT_W'(1);

    case (state)
      IDLE: begin
        bclk_n = 1'b0;
        if (fifo_count != '0) begin
          pop     = 1'b1;
          hold_n  = fifo_dout;
          shift_n = fifo_dout;
          sdata_n = fifo_dout[DATA_WIDTH-1];
          lrclk_n = 1'b0;
          div_n   = '0;
          bit_n   = '0;
          state_n = RUN;
        end
      end
      RUN: begin
        if (div_cnt == DIV_LAST) begin
          div_n  = '0;
          bclk_n = !bclk_r;
          if (bclk_r) begin
            bit_n = bit_inc;
            if (bit_inc == BIT_HALF) begin
              lrclk_n = 1'b1;
              shift_n = hold;
              sdata_n = hold[DATA_WIDTH-1];
            end else if (bit_inc == '0) begin
              lrclk_n = 1'b0;
              if (fifo_count != '0) begin
                pop     = 1'b1;
                hold_n  = fifo_dout;
                shift_n = fifo_dout;
                sdata_n = fifo_dout[DATA_WIDTH-1];
              end else begin
                shift_n      = hold;
                sdata_n      = hold[DATA_WIDTH-1];
                underrun_set = 1'b1;
              end
            end else begin
              shift_n = shift << 1;
              sdata_n = shift[DATA_WIDTH-2];
            end
          end
        end else begin
          div_n = div_cnt + DIV_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase

    // A set event on the same edge as clear_flags leaves the flag set.
    overflow_set = bus.sample_valid && fifo_full_int && !pop;
    overflow_n   = (bus.clear_flags ? 1'b0 : overflow_r) | overflow_set;
    underrun_n   = (bus.clear_flags ? 1'b0 : underrun_r) | underrun_set;
  end

  assign bus.fifo_full = fifo_full_int;
  assign bus.bclk      = bclk_r;
  assign bus.lrclk     = lrclk_r;
  assign bus.sdata     = sdata_r;
  assign bus.overflow  = overflow_r;
  assign bus.underrun  = underrun_r;

endmodule

// File: tb/tb_audio_serializer.sv
// Self-checking bench: a frame-level reference model predicts every output on
// every clock, plus directed checks for reset, latency, overflow and underrun.
module tb_audio_serializer;

  localparam int DW    = 16;
  localparam int FD    = 4;
  localparam int CD    = 2;
  localparam int BITT  = 2 * CD;
  localparam int FRAME = 2 * DW * BITT;

  logic clock = 1'b0;
  logic reset = 1'b1;

  audio_serializer_if #(.DATA_WIDTH(DW)) bus ();

  audio_serializer #(
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (FD),
    .CLK_DIV    (CD)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a sample queue plus the frame position since the first pop.
  logic [DW-1:0] m_q[$];
  logic [DW-1:0] m_cur     = '0;
  bit            m_running = 1'b0;
  int            m_cyc     = 0;
  bit            m_ovf     = 1'b0;
  bit            m_und     = 1'b0;
  bit            m_pop, m_start, m_drop;

  initial forever begin
    @(posedge clock or negedge reset);
    if (!reset) begin
      m_q.delete();
      m_running = 1'b0;
      m_cyc     = 0;
      m_cur     = '0;
      m_ovf     = 1'b0;
      m_und     = 1'b0;
    end else begin
      m_pop   = 1'b0;
      m_start = 1'b0;
      if (!m_running) begin
        if (m_q.size() > 0) begin
          m_pop     = 1'b1;
          m_running = 1'b1;
          m_cyc     = 0;
        end
      end else begin
        m_cyc++;
        if (m_cyc % FRAME == 0) begin
          m_start = 1'b1;
          if (m_q.size() > 0) m_pop = 1'b1;
        end
      end
      m_drop = bus.sample_valid && (m_q.size() == FD) && !m_pop;
      if (m_pop) m_cur = m_q.pop_front();
      if (bus.sample_valid && !m_drop) m_q.push_back(bus.sample_in);
      if (bus.clear_flags) begin
        m_ovf = 1'b0;
        m_und = 1'b0;
      end
      if (m_drop) m_ovf = 1'b1;
      if (m_start && !m_pop) m_und = 1'b1;
    end
  end

  // Expected link state is derived from the position inside the frame.
  initial forever begin
    int idx;
    bit e_bclk, e_lrclk, e_sdata;
    @(negedge clock);
    e_bclk  = 1'b0;
    e_lrclk = 1'b0;
    e_sdata = 1'b0;
    if (m_running) begin
      idx     = (m_cyc / BITT) % (2 * DW);
      e_bclk  = (m_cyc % BITT) >= CD;
      e_lrclk = idx >= DW;
      e_sdata = m_cur[DW - 1 - (idx % DW)];
    end
    checkOutput("bclk",      32'(bus.bclk),      32'(e_bclk));
    checkOutput("lrclk",     32'(bus.lrclk),     32'(e_lrclk));
    checkOutput("sdata",     32'(bus.sdata),     32'(e_sdata));
    checkOutput("fifo_full", 32'(bus.fifo_full), 32'(m_q.size() == FD));
    checkOutput("overflow",  32'(bus.overflow),  32'(m_ovf));
    checkOutput("underrun",  32'(bus.underrun),  32'(m_und));
  end

  task automatic applyStimulus(input logic [DW-1:0] v);
    bus.sample_in    = v;
    bus.sample_valid = 1'b1;
    @(negedge clock);
    bus.sample_valid = 1'b0;
  endtask

  task automatic pulseClear();
    bus.clear_flags = 1'b1;
    @(negedge clock);
    bus.clear_flags = 1'b0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_bclk"},      32'(bus.bclk),      32'd0);
    checkOutput({tag, "_lrclk"},     32'(bus.lrclk),     32'd0);
    checkOutput({tag, "_sdata"},     32'(bus.sdata),     32'd0);
    checkOutput({tag, "_fifo_full"}, 32'(bus.fifo_full), 32'd0);
    checkOutput({tag, "_overflow"},  32'(bus.overflow),  32'd0);
    checkOutput({tag, "_underrun"},  32'(bus.underrun),  32'd0);
  endtask

  task automatic midRunReset(input string tag);
    @(posedge clock);
    #2 reset = 1'b0;
    #1 checkAllZero(tag);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
  endtask

  logic [DW-1:0] seq [8];

  initial begin
    bus.sample_in    = '0;
    bus.sample_valid = 1'b0;
    bus.clear_flags  = 1'b0;
    #1 reset = 1'b0;
    repeat (3) @(negedge clock);
    checkAllZero("reset");
    reset = 1'b1;
    repeat (2) @(negedge clock);

    $display("[TB] single sample A5C3 and underrun");
    applyStimulus(16'hA5C3);
    checkOutput("latency_before", 32'(bus.sdata), 32'd0);
    @(negedge clock);
    checkOutput("latency_msb",   32'(bus.sdata), 32'd1);
    checkOutput("latency_lrclk", 32'(bus.lrclk), 32'd0);
    repeat (FRAME + 10) @(negedge clock);
    checkOutput("underrun_set", 32'(bus.underrun), 32'd1);
    pulseClear();
    checkOutput("underrun_clear", 32'(bus.underrun), 32'd0);

    $display("[TB] reset during RUN");
    repeat (40) @(negedge clock);
    midRunReset("midrun");

    $display("[TB] overflow burst");
    for (int v = 1; v <= 5; v++) applyStimulus(DW'(v));
    checkOutput("full_after5", 32'(bus.fifo_full), 32'd1);
    checkOutput("no_ovf_after5", 32'(bus.overflow), 32'd0);
    applyStimulus(16'd6);
    checkOutput("ovf_after6", 32'(bus.overflow), 32'd1);
    checkOutput("full_after6", 32'(bus.fifo_full), 32'd1);
    repeat (6 * FRAME) @(negedge clock);
    pulseClear();

    $display("[TB] negative full-scale sample");
    applyStimulus(16'h8000);
    repeat (2 * FRAME) @(negedge clock);

    $display("[TB] steady one sample per frame");
    midRunReset("steady");
    seq[0] = 16'h0000;
    seq[1] = 16'hFFFF;
    seq[2] = 16'h0001;
    seq[3] = 16'h7FFF;
    for (int i = 4; i < 8; i++) seq[i] = DW'($urandom());
    applyStimulus(seq[0]);
    repeat (10) @(negedge clock);
    for (int i = 1; i < 8; i++) begin
      applyStimulus(seq[i]);
      repeat (FRAME - 1) @(negedge clock);
    end
    repeat (FRAME - 20) @(negedge clock);
    checkOutput("steady_overflow", 32'(bus.overflow), 32'd0);
    checkOutput("steady_underrun", 32'(bus.underrun), 32'd0);
    repeat (30) @(negedge clock);

    $display("[TB] random traffic");
    for (int i = 0; i < 30; i++) begin
      repeat ($urandom_range(0, 300)) @(negedge clock);
      for (int b = 0; b < int'($urandom_range(1, 3)); b++) applyStimulus(DW'($urandom()));
      if ($urandom_range(0, 3) == 0) pulseClear();
    end
    repeat (FRAME) @(negedge clock);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
